mips_dmem_responder: RTL and testbench



---
 rtl/mips_dmem_responder_if.sv | 23 ++
 rtl/mips_dmem_responder.sv | 137 +++++++++++++
 tb/tb_mips_dmem_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_dmem_responder_if.sv
// Data-memory port bundle between the CPU (master) and the data-memory
// responder (slave), plus the console TX byte stream towards its consumer.
interface mips_dmem_responder_if;
  logic        en;
  logic [3:0]  mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output en, mem_write_en, mem_read_en, mem_addr, mem_write_data, tx_ready,
    input  mem_read_data, tx_data, tx_valid
  );

  modport slave (
    input  en, mem_write_en, mem_read_en, mem_addr, mem_write_data, tx_ready,
    output mem_read_data, tx_data, tx_valid
  );
endinterface

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the pipelined CPU: word/byte RAM access plus a
// small MMIO window (console TX FIFO, status register, clearable cycle counter).
module mips_dmem_responder #(
  parameter int RAM_AW  = 10,
  parameter int FIFO_AW = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  mips_dmem_responder_if.slave bus
);

  localparam int RAM_DEPTH  = 1 << RAM_AW;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_COUNT = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   COUNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CYCLE  = 2'd2,
    REG_RSVD   = 2'd3
  } mmio_reg_t;

  logic [31:0]        ram [RAM_DEPTH];
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW:0]   count;
  logic               overflow;
  logic [31:0]        cycle_count;

  logic              is_mmio;
  logic [RAM_AW-1:0] ram_idx;
  mmio_reg_t         reg_sel;
  logic              any_write;
  logic              ram_write;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              status_wr;
  logic              cycle_wr;
  logic              empty;
  logic              full;
  logic [31:0]       mmio_rdata;
  logic              unused_addr;

  // Upper RAM address bits alias and the byte offset is the CPU's business.
  assign unused_addr = ^{bus.mem_addr[30:RAM_AW+2], bus.mem_addr[1:0]};

  assign is_mmio   = bus.mem_addr[31];
  assign ram_idx   = bus.mem_addr[RAM_AW+1:2];
  assign reg_sel   = mmio_reg_t'(bus.mem_addr[3:2]);
  assign any_write = |bus.mem_write_en;
  assign ram_write = bus.en && !is_mmio;
  assign push_req  = bus.en && is_mmio && (reg_sel == REG_TXDATA) && any_write;
  assign status_wr = bus.en && is_mmio && (reg_sel == REG_STATUS) && any_write;
  assign cycle_wr  = bus.en && is_mmio && (reg_sel == REG_CYCLE) && any_write;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign pop     = !empty && bus.tx_ready;
  assign push_ok = push_req && (!full || pop);

  // Head byte is only meaningful while the FIFO holds data; otherwise show 0.
  assign bus.tx_valid = !empty;
  assign bus.tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

  // MMIO read mux; reads reflect register state before this edge's updates.
  always_comb begin
    mmio_rdata = 32'h0;
    case (reg_sel)
      REG_STATUS: mmio_rdata = {16'h0, 8'(count), 5'b0, overflow, full, empty};
      REG_CYCLE:  mmio_rdata = cycle_count;
      default:    mmio_rdata = 32'h0;
    endcase
  end

  // Byte-lane RAM writes, big-endian lanes (bit3 is the MSB byte).
  always_ff @(posedge clk) begin
    if (ram_write) begin
      if (bus.mem_write_en[3]) ram[ram_idx][31:24] <= bus.mem_write_data[31:24];
      if (bus.mem_write_en[2]) ram[ram_idx][23:16] <= bus.mem_write_data[23:16];
      if (bus.mem_write_en[1]) ram[ram_idx][15:8]  <= bus.mem_write_data[15:8];
      if (bus.mem_write_en[0]) ram[ram_idx][7:0]   <= bus.mem_write_data[7:0];
    end
  end

  // Registered load data; sampling the RAM alongside the write gives read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_read_data <= 32'h0;
    end else if (bus.en && bus.mem_read_en) begin
      bus.mem_read_data <= is_mmio ? mmio_rdata : ram[ram_idx];
    end
  end

  // TX FIFO storage, written only when a push is accepted.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= bus.mem_write_data[7:0];
    end
  end

  // TX FIFO pointers, occupancy and sticky overflow flag; pops ignore en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end else if (status_wr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Free-running cycle counter; a CYCLE write clears it in place of the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= 32'h0;
    end else if (bus.en) begin
      cycle_count <= cycle_wr ? 32'h0 : cycle_count + 32'h1;
    end
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench for the data-memory responder: stimulus pushes expected
// load data and TX bytes into queues, monitors pop and compare them.
module tb_mips_dmem_responder;

  localparam logic [31:0] TXDATA_ADDR = 32'h8000_0000;
  localparam logic [31:0] STATUS_ADDR = 32'h8000_0004;
  localparam logic [31:0] CYCLE_ADDR  = 32'h8000_0008;
  localparam logic [31:0] RSVD_ADDR   = 32'h8000_000C;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic rd_pending;
  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];

  mips_dmem_responder_if bus();

  mips_dmem_responder #(.RAM_AW(10), .FIFO_AW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic e, input logic [3:0] we, input logic rd,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rd);
    bus.en             = e;
    bus.mem_write_en   = we;
    bus.mem_read_en    = rd;
    bus.mem_addr       = addr;
    bus.mem_write_data = wdata;
    if (e && rd) rd_q.push_back(exp_rd);
    @(posedge clk);
    #1;
    bus.en           = 1'b1;
    bus.mem_write_en = 4'h0;
    bus.mem_read_en  = 1'b0;
  endtask

  task automatic store_word(input logic [31:0] addr, input logic [31:0] data);
    apply_stimulus(1'b1, 4'hF, 1'b0, addr, data, 32'h0);
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] expected);
    apply_stimulus(1'b1, 4'h0, 1'b1, addr, 32'h0, expected);
  endtask

  task automatic idle_edge(input logic e);
    apply_stimulus(e, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic accepted);
    if (accepted) tx_q.push_back(b);
    apply_stimulus(1'b1, 4'b0001, 1'b0, TXDATA_ADDR, {4{b}}, 32'h0);
  endtask

  task automatic drain_fifo();
    bit drained;
    drained = 1'b0;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 20 && !drained; i++) begin
      @(negedge clk);
      if (!bus.tx_valid) drained = 1'b1;
    end
    check_output("tx_drained", 32'(drained), 32'h1);
    check_output("tx_queue_left", 32'(tx_q.size()), 32'h0);
  endtask

  // Note which edges carried a load so the monitor knows when data is due.
  always @(posedge clk) begin
    rd_pending = rst_n && bus.en && bus.mem_read_en;
  end

  // Monitor: compare load data one cycle after the request and every popped TX byte.
  always @(negedge clk) begin
    if (rst_n && rd_pending) begin
      if (rd_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL read_unexpected: got 0x%08h, expected no load", bus.mem_read_data);
      end else begin
        check_output("read_data", bus.mem_read_data, rd_q.pop_front());
      end
    end
    if (rst_n && bus.tx_valid && bus.tx_ready) begin
      if (tx_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL tx_unexpected: got 0x%02h, expected no byte", bus.tx_data);
      end else begin
        check_output("tx_byte", 32'(bus.tx_data), 32'(tx_q.pop_front()));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    miscompares++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus sequence.
  initial begin
    logic [31:0] lane_exp [4];
    lane_exp[0] = 32'hAB00_0000;
    lane_exp[1] = 32'h00AB_0000;
    lane_exp[2] = 32'h0000_AB00;
    lane_exp[3] = 32'h0000_00AB;

    vectors            = 0;
    miscompares        = 0;
    rd_pending         = 1'b0;
    rst_n              = 1'b0;
    bus.en             = 1'b0;
    bus.mem_write_en   = 4'h0;
    bus.mem_read_en    = 1'b0;
    bus.mem_addr       = 32'h0;
    bus.mem_write_data = 32'h0;
    bus.tx_ready       = 1'b0;

    #12;
    check_output("reset_read_data", bus.mem_read_data, 32'h0);
    check_output("reset_tx_valid", 32'(bus.tx_valid), 32'h0);
    check_output("reset_tx_data", 32'(bus.tx_data), 32'h0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    bus.en = 1'b1;

    // Word store/load, hold with en low, en-gated write, address aliasing.
    store_word(32'h10, 32'hDEAD_BEEF);
    load_word(32'h10, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      idle_edge(1'b0);
      @(negedge clk);
      check_output("hold_en_low", bus.mem_read_data, 32'hDEAD_BEEF);
    end
    apply_stimulus(1'b0, 4'hF, 1'b0, 32'h10, 32'h0, 32'h0);
    load_word(32'h10, 32'hDEAD_BEEF);
    load_word(32'h1010, 32'hDEAD_BEEF);

    // Byte lane mapping at all four offsets.
    for (int k = 0; k < 4; k++) begin
      store_word(32'h20, 32'h0);
      apply_stimulus(1'b1, 4'b1000 >> k, 1'b0, 32'h20 + 32'(k), 32'hABAB_ABAB, 32'h0);
      load_word(32'h20, lane_exp[k]);
    end

    // Read-before-write in a single request.
    store_word(32'h30, 32'h5);
    apply_stimulus(1'b1, 4'hF, 1'b1, 32'h30, 32'h1, 32'h5);
    load_word(32'h30, 32'h1);

    // Write-only and reserved MMIO registers read as zero.
    load_word(TXDATA_ADDR, 32'h0);
    load_word(RSVD_ADDR, 32'h0);

    // FIFO overflow, overflow clear, drain.
    for (int b = 1; b <= 9; b++) push_byte(8'(b), b <= 8);
    load_word(STATUS_ADDR, 32'h0000_0806);
    store_word(STATUS_ADDR, 32'h0);
    load_word(STATUS_ADDR, 32'h0000_0802);
    drain_fifo();
    load_word(STATUS_ADDR, 32'h0000_0001);
    bus.tx_ready = 1'b0;

    // Full FIFO with simultaneous pop and push.
    for (int b = 8'h11; b <= 8'h18; b++) push_byte(8'(b), 1'b1);
    bus.tx_ready = 1'b1;
    push_byte(8'h55, 1'b1);
    bus.tx_ready = 1'b0;
    load_word(STATUS_ADDR, 32'h0000_0802);
    drain_fifo();
    bus.tx_ready = 1'b0;

    // Cycle counter clear, count with en high, hold with en low.
    store_word(CYCLE_ADDR, 32'h0);
    for (int i = 0; i < 10; i++) idle_edge(1'b1);
    for (int i = 0; i < 5; i++) idle_edge(1'b0);
    load_word(CYCLE_ADDR, 32'd10);

    // Asynchronous reset in the middle of activity.
    push_byte(8'h77, 1'b1);
    push_byte(8'h78, 1'b1);
    load_word(32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_read_data", bus.mem_read_data, 32'h0);
    check_output("async_rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    check_output("async_rst_tx_data", 32'(bus.tx_data), 32'h0);
    tx_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load_word(STATUS_ADDR, 32'h0000_0001);
    load_word(CYCLE_ADDR, 32'h1);
    idle_edge(1'b1);
    @(negedge clk);

    check_output("read_queue_left", 32'(rd_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
